// File: rtl/dsm_ctrl_pkg.sv
// Shared types and constants for the DSM fractional-word ramp controller.
// The LFSR constants are only consumed when DSM_CTRL_DITHER_EN is defined.
package dsm_ctrl_pkg;

    localparam int DEF_W       = 7;
    localparam int DEF_DWELL_W = 8;

    localparam int             LFSR_W    = 7;
    localparam logic [6:0]     LFSR_POLY = 7'h60;
    localparam logic [6:0]     LFSR_SEED = 7'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RAMP
    } state_e;

    // Fibonacci step for x^7 + x^6 + 1: taps are the bits set in LFSR_POLY.
    function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_POLY)};
    endfunction

endpackage

// File: rtl/dsm_dwell_cnt.sv
// Dwell counter: loads a count, decrements to zero and holds there.
// Exposes only the zero flag to the controller.
module dsm_dwell_cnt
    import dsm_ctrl_pkg::*;
#(
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dsm_frac_ctrl.sv
// Ramp controller that steps the DSM fractional word toward a requested target.
// Optional IDLE dithering of the output word is enabled by defining DSM_CTRL_DITHER_EN.
module dsm_frac_ctrl
    import dsm_ctrl_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [W-1:0]       req_target,
    input  logic [W-1:0]       req_step,
    input  logic [DWELL_W-1:0] req_dwell,
    input  logic               req_clear,
    input  logic               abort,
    output logic [W-1:0]       acc_word,
    output logic               acc_clr,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [W-1:0]       word_q, word_d;
    logic [W-1:0]       target_q, target_d;
    logic [W-1:0]       step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               cntLoad;
    logic [DWELL_W-1:0] cntLoadVal;
    logic               cntZero;
    logic               doneInt;

    logic [W:0]         sumUp;
    logic [W:0]         diffDn;
    logic [W-1:0]       nextWord;

    dsm_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell (
        .clk_i      (Clk),
        .rst_ni     (reset),
        .load_i     (cntLoad),
        .load_val_i (cntLoadVal),
        .zero_o     (cntZero)
    );

    // Clamp each move to the remaining distance so the word never overshoots or wraps.
    always_comb begin
        sumUp    = {1'b0, word_q} + {1'b0, step_q};
        diffDn   = {1'b0, word_q} - {1'b0, step_q};
        nextWord = target_q;
        if (target_q > word_q) begin
            if ((step_q != '0) && (sumUp < {1'b0, target_q})) begin
                nextWord = sumUp[W-1:0];
            end
        end else begin
            if ((step_q != '0) && !diffDn[W] && (diffDn[W-1:0] > target_q)) begin
                nextWord = diffDn[W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        target_d   = target_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        cntLoad    = 1'b0;
        cntLoadVal = dwell_q;
        doneInt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    target_d = req_target;
                    step_d   = req_step;
                    dwell_d  = req_dwell;
                    cntLoad  = 1'b1;
                    if (req_clear) begin
                        state_d    = ST_CLEAR;
                        word_d     = '0;
                        cntLoadVal = DWELL_W'(1);
                    end else begin
                        state_d    = ST_RAMP;
                        cntLoadVal = req_dwell;
                    end
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cntZero) begin
                    state_d = ST_RAMP;
                    cntLoad = 1'b1;
                end
            end
            ST_RAMP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (word_q == target_q) begin
                    doneInt = 1'b1;
                    state_d = ST_IDLE;
                end else if (cntZero) begin
                    word_d  = nextWord;
                    cntLoad = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            target_q <= target_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
        end
    end

`ifdef DSM_CTRL_DITHER_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic [W:0]        dithSum;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsrNext(lfsr_q);
        end
    end

    // Dither only while parked; saturate so a full-scale word cannot wrap to zero.
    always_comb begin
        dithSum  = {1'b0, word_q} + (W+1)'(lfsr_q[0]);
        acc_word = word_q;
        if (state_q == ST_IDLE) begin
            acc_word = dithSum[W] ? '1 : dithSum[W-1:0];
        end
    end
`else
    assign acc_word = word_q;
`endif

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign acc_clr   = (state_q == ST_CLEAR);
    assign done      = doneInt;

endmodule

// File: tb/tb_dsm_frac_ctrl.sv
// Self-checking bench for dsm_frac_ctrl (default build, dithering disabled).
// Expected traces come from a per-request timeline model built from the ramp rules.
module tb_dsm_frac_ctrl;

    localparam int W       = 7;
    localparam int DWELL_W = 8;

    logic               Clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [W-1:0]       req_target;
    logic [W-1:0]       req_step;
    logic [DWELL_W-1:0] req_dwell;
    logic               req_clear;
    logic               abort;
    logic [W-1:0]       acc_word;
    logic               acc_clr;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int modelWord = 0;

    typedef struct {
        int word;
        bit clr;
        bit done;
    } entry_t;

    entry_t tl[$];

    dsm_frac_ctrl #(.W(W), .DWELL_W(DWELL_W)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .req_step   (req_step),
        .req_dwell  (req_dwell),
        .req_clear  (req_clear),
        .abort      (abort),
        .acc_word   (acc_word),
        .acc_clr    (acc_clr),
        .busy       (busy),
        .done       (done)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".word"},  32'(acc_word),  32'(modelWord));
        checkOutput({tag, ".busy"},  32'(busy),      32'd0);
        checkOutput({tag, ".ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, ".done"},  32'(done),      32'd0);
        checkOutput({tag, ".clr"},   32'(acc_clr),   32'd0);
    endtask

    // Cycle-by-cycle outputs after accept: two clear cycles, then dwell+1 cycles per word
    // value held before each move, then one done cycle showing the target.
    task automatic buildTimeline(input int startWord, input int tgt, input int stp,
                                 input int dw, input bit clr);
        int w;
        int diff;
        int mag;
        int mv;
        tl.delete();
        w = startWord;
        if (clr) begin
            tl.push_back('{word: 0, clr: 1'b1, done: 1'b0});
            tl.push_back('{word: 0, clr: 1'b1, done: 1'b0});
            w = 0;
        end
        while (w != tgt) begin
            for (int k = 0; k <= dw; k++) begin
                tl.push_back('{word: w, clr: 1'b0, done: 1'b0});
            end
            diff = tgt - w;
            mag  = (diff < 0) ? -diff : diff;
            mv   = (stp == 0 || stp > mag) ? mag : stp;
            w    = (diff > 0) ? w + mv : w - mv;
        end
        tl.push_back('{word: tgt, clr: 1'b0, done: 1'b1});
    endtask

    task automatic applyStimulus(input int tgt, input int stp, input int dw,
                                 input bit clr, input bit abortWithReq);
        req_valid  = 1'b1;
        req_target = W'(tgt);
        req_step   = W'(stp);
        req_dwell  = DWELL_W'(dw);
        req_clear  = clr;
        abort      = abortWithReq;
    endtask

    // Called just after a falling edge while the DUT is idle.
    task automatic runRequest(input string tag, input int tgt, input int stp, input int dw,
                              input bit clr, input bit abortWithReq, input int abortWord,
                              input bit resetInClear);
        applyStimulus(tgt, stp, dw, clr, abortWithReq);
        @(negedge Clk);
        req_valid = 1'b0;
        abort     = 1'b0;
        buildTimeline(modelWord, tgt, stp, dw, clr);
        for (int i = 0; i < tl.size(); i++) begin
            checkOutput({tag, ".word"},  32'(acc_word),  32'(tl[i].word));
            checkOutput({tag, ".clr"},   32'(acc_clr),   32'(tl[i].clr));
            checkOutput({tag, ".done"},  32'(done),      32'(tl[i].done));
            checkOutput({tag, ".busy"},  32'(busy),      32'd1);
            checkOutput({tag, ".ready"}, 32'(req_ready), 32'd0);
            if (resetInClear && tl[i].clr) begin
                req_valid = 1'b0;
                reset     = 1'b0;
                @(negedge Clk);
                reset     = 1'b1;
                modelWord = 0;
                checkIdle({tag, ".rst"});
                return;
            end
            if (abortWord >= 0 && !tl[i].clr && tl[i].word == abortWord && !tl[i].done) begin
                req_valid = 1'b0;
                abort     = 1'b1;
                @(negedge Clk);
                abort     = 1'b0;
                modelWord = tl[i].word;
                checkIdle({tag, ".abort"});
                @(negedge Clk);
                checkIdle({tag, ".abort2"});
                return;
            end
            req_valid  = 1'($urandom_range(0, 1));
            req_target = W'($urandom);
            req_step   = W'($urandom);
            req_dwell  = DWELL_W'($urandom);
            req_clear  = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
        req_valid = 1'b0;
        modelWord = tgt;
        checkIdle({tag, ".idle"});
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_target = '0;
        req_step   = '0;
        req_dwell  = '0;
        req_clear  = 1'b0;
        abort      = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        modelWord = 0;
        checkIdle("reset");
        reset = 1'b1;
        @(negedge Clk);

        runRequest("ramp_up",   20, 5, 2, 1'b0, 1'b0, -1, 1'b0);
        runRequest("ramp_down",  3, 8, 0, 1'b0, 1'b0, -1, 1'b0);
        runRequest("clear_jump",10, 0, 1, 1'b1, 1'b0, -1, 1'b0);
        runRequest("abort",     30, 5, 2, 1'b1, 1'b0, 15, 1'b0);
        runRequest("abort_req", 40, 0, 0, 1'b0, 1'b1, -1, 1'b0);
        runRequest("rst_clear", 50, 3, 0, 1'b1, 1'b0, -1, 1'b1);
        runRequest("same_word",  0, 5, 1, 1'b0, 1'b0, -1, 1'b0);
        runRequest("full_scale",127, 100, 0, 1'b0, 1'b0, -1, 1'b0);
        runRequest("to_zero",    0, 126, 1, 1'b0, 1'b0, -1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            runRequest("random", int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                       1'b0, -1, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge Clk);
                checkIdle("random_gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
